// File: rtl/mem_resp_unit.sv
// mem_resp_unit
// Buffers completed memory instructions from the load/store queue, replays
// each one lane by lane against a single-port memory, then writes load
// results back to the register file and releases the scoreboard entry.
module mem_resp_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    done_bit_q,
    input  logic                    instr_bit_q,
    input  logic [1:0]              warp_num_q,
    input  logic [3:0]              dest_reg_q,
    input  logic [8*ADDR_WIDTH-1:0] addr_q,
    input  logic [8*DATA_WIDTH-1:0] store_data_q,
    output logic                    mem_re,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    rf_we,
    output logic [1:0]              rf_warp,
    output logic [3:0]              rf_reg,
    output logic [8*DATA_WIDTH-1:0] rf_wdata,
    output logic                    release_valid,
    output logic [1:0]              release_warp,
    output logic [3:0]              release_reg,
    output logic                    release_is_store,
    output logic                    busy,
    output logic                    overflow
);

    localparam int LANES = 8;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DRAIN  = 2'd2,
        S_WB     = 2'd3
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Completion buffer
    // ------------------------------------------------------------------
    logic                    fifo_instr_q [FIFO_DEPTH];
    logic [1:0]              fifo_warp_q  [FIFO_DEPTH];
    logic [3:0]              fifo_reg_q   [FIFO_DEPTH];
    logic [8*ADDR_WIDTH-1:0] fifo_addr_q  [FIFO_DEPTH];
    logic [8*DATA_WIDTH-1:0] fifo_data_q  [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic push_ok;
    logic push_drop;

    // Pointers wrap explicitly so any depth indexes the arrays safely.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign fifo_full  = (count_q == DEPTH_CNT);
    assign fifo_empty = (count_q == '0);

    // The engine only takes a new entry while idle.
    assign pop = (state_q == S_IDLE) && !fifo_empty;

    // A push into a full buffer still lands when the head leaves this cycle.
    // Strobes coincident with reset are discarded.
    assign push_ok   = done_bit_q && !reset && (!fifo_full || pop);
    assign push_drop = done_bit_q && !reset && fifo_full && !pop;

    // Next pointer / count / sticky overflow values.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (push_drop) begin
            overflow_d = 1'b1;
        end
    end

    // Buffer control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Buffer storage; contents are meaningless until the count covers them.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_instr_q[wr_ptr_q] <= instr_bit_q;
            fifo_warp_q[wr_ptr_q]  <= warp_num_q;
            fifo_reg_q[wr_ptr_q]   <= dest_reg_q;
            fifo_addr_q[wr_ptr_q]  <= addr_q;
            fifo_data_q[wr_ptr_q]  <= store_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Working registers for the entry being serviced
    // ------------------------------------------------------------------
    logic                    wk_instr_q;
    logic [1:0]              wk_warp_q;
    logic [3:0]              wk_reg_q;
    logic [8*ADDR_WIDTH-1:0] wk_addr_q;
    logic [8*DATA_WIDTH-1:0] wk_data_q;
    logic [2:0]              lane_q;

    // Load the head entry on pop and step the lane counter while accessing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wk_instr_q <= 1'b0;
            wk_warp_q  <= '0;
            wk_reg_q   <= '0;
            wk_addr_q  <= '0;
            wk_data_q  <= '0;
            lane_q     <= '0;
        end else if (pop) begin
            wk_instr_q <= fifo_instr_q[rd_ptr_q];
            wk_warp_q  <= fifo_warp_q[rd_ptr_q];
            wk_reg_q   <= fifo_reg_q[rd_ptr_q];
            wk_addr_q  <= fifo_addr_q[rd_ptr_q];
            wk_data_q  <= fifo_data_q[rd_ptr_q];
            lane_q     <= '0;
        end else if (state_q == S_ACCESS) begin
            lane_q <= lane_q + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Per-lane unpacking and read-data capture
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] lane_addr [LANES];
    logic [DATA_WIDTH-1:0] lane_data [LANES];

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic                  cap_en;
            logic [DATA_WIDTH-1:0] rdata_q;

            assign lane_addr[gi] = wk_addr_q[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign lane_data[gi] = wk_data_q[gi*DATA_WIDTH +: DATA_WIDTH];
            assign rf_wdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata_q;

            // Read data trails mem_re by one cycle: lane k lands while lane
            // k+1 is being addressed, and the last lane lands in DRAIN.
            if (gi == LANES - 1) begin : g_last
                assign cap_en = (state_q == S_DRAIN);
            end else begin : g_mid
                assign cap_en = (state_q == S_ACCESS) && !wk_instr_q
                                && (lane_q == 3'(gi + 1));
            end

            // Read-data buffer lane, cleared whenever a new entry starts.
            always_ff @(posedge clk) begin
                if (reset || pop) begin
                    rdata_q <= '0;
                end else if (cap_en) begin
                    rdata_q <= mem_rdata;
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: stores skip DRAIN since they return no data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (lane_q == 3'd7) begin
                    state_d = wk_instr_q ? S_WB : S_DRAIN;
                end
            end
            S_DRAIN: state_d = S_WB;
            S_WB:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: strobes exist only in their own states.
    always_comb begin
        mem_re           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        rf_we            = 1'b0;
        rf_warp          = '0;
        rf_reg           = '0;
        release_valid    = 1'b0;
        release_warp     = '0;
        release_reg      = '0;
        release_is_store = 1'b0;
        case (state_q)
            S_ACCESS: begin
                mem_addr = lane_addr[lane_q];
                if (wk_instr_q) begin
                    mem_we    = 1'b1;
                    mem_wdata = lane_data[lane_q];
                end else begin
                    mem_re = 1'b1;
                end
            end
            S_WB: begin
                release_valid    = 1'b1;
                release_warp     = wk_warp_q;
                release_reg      = wk_reg_q;
                release_is_store = wk_instr_q;
                if (!wk_instr_q) begin
                    rf_we   = 1'b1;
                    rf_warp = wk_warp_q;
                    rf_reg  = wk_reg_q;
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state_q != S_IDLE) || !fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_mem_resp_unit.sv
// Bench for mem_resp_unit: directed scenarios plus random traffic, checked
// against a schedule-level reference model and a shadow memory.
`timescale 1ns/1ps
module tb_mem_resp_unit;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            done_bit_q;
    logic            instr_bit_q;
    logic [1:0]      warp_num_q;
    logic [3:0]      dest_reg_q;
    logic [8*AW-1:0] addr_q;
    logic [8*DW-1:0] store_data_q;
    logic            mem_re;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;
    logic            rf_we;
    logic [1:0]      rf_warp;
    logic [3:0]      rf_reg;
    logic [8*DW-1:0] rf_wdata;
    logic            release_valid;
    logic [1:0]      release_warp;
    logic [3:0]      release_reg;
    logic            release_is_store;
    logic            busy;
    logic            overflow;
    logic            mem_init;

    always #5 clk = ~clk;

    mem_resp_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .done_bit_q(done_bit_q), .instr_bit_q(instr_bit_q),
        .warp_num_q(warp_num_q), .dest_reg_q(dest_reg_q), .addr_q(addr_q),
        .store_data_q(store_data_q), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_warp(rf_warp), .rf_reg(rf_reg), .rf_wdata(rf_wdata),
        .release_valid(release_valid), .release_warp(release_warp),
        .release_reg(release_reg), .release_is_store(release_is_store),
        .busy(busy), .overflow(overflow)
    );

    // Memory the DUT talks to: read data one cycle after mem_re.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'(240 + i);
            mem_rdata <= '0;
        end else begin
            if (mem_re) mem_rdata <= mem[mem_addr];
            if (mem_we) mem[mem_addr] <= mem_wdata;
        end
    end

    // ---------------- reference model ----------------
    // Each accepted entry gets its pop cycle and WB cycle from the latency
    // rules: pop when the engine is idle and the entry is present, eight
    // access cycles, one drain cycle for loads, then WB.
    typedef struct packed {
        bit          instr;
        bit [1:0]    warp;
        bit [3:0]    rg;
        bit [63:0]   addr;
        bit [127:0]  data;
        int          push;
        int          pop;
        int          wb;
    } ent_t;

    ent_t          sched[$];
    logic [DW-1:0] ref_mem [256];
    int            eng_free;
    int            ovf_from;
    int            cyc;
    int            n_checks;
    int            n_fail;

    // Observations taken from the DUT, compared against constants later.
    int              first_acc;
    int              last_acc;
    int              last_wb;
    int              wb_count;
    int              wb_hist[$];
    logic [8*DW-1:0] last_rf;
    logic            last_store;

    task automatic check_val(input string tag, input logic [127:0] got,
                             input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset(input int c);
        sched.delete();
        eng_free = c + 1;
        ovf_from = -1;
    endtask

    task automatic model_push(input int c);
        ent_t e;
        int   occ;
        occ = 0;
        foreach (sched[i]) if (sched[i].push < c && sched[i].pop > c) occ++;
        if (occ < DEPTH) begin
            e.instr = instr_bit_q;
            e.warp  = warp_num_q;
            e.rg    = dest_reg_q;
            e.addr  = addr_q;
            e.data  = store_data_q;
            e.push  = c;
            e.pop   = (c + 1 > eng_free) ? c + 1 : eng_free;
            e.wb    = e.pop + (instr_bit_q ? 9 : 10);
            eng_free = e.wb + 1;
            sched.push_back(e);
        end else if (ovf_from < 0) begin
            ovf_from = c + 1;
        end
    endtask

    task automatic check_cycle();
        ent_t         e;
        bit           act, exp_re, exp_we, exp_wb, exp_busy, exp_ovf;
        int           lane;
        logic [127:0] exp_vec;
        int           c;
        c = cyc;
        if (mem_re || mem_we) begin
            if (first_acc < 0) first_acc = c;
            last_acc = c;
        end
        if (release_valid) begin
            last_wb    = c;
            wb_count++;
            wb_hist.push_back(c);
            last_rf    = rf_wdata;
            last_store = release_is_store;
        end
        if (reset) return;
        while (sched.size() > 0 && sched[0].wb < c) void'(sched.pop_front());
        act = 0; exp_re = 0; exp_we = 0; lane = 0; e = '0;
        if (sched.size() > 0) begin
            e   = sched[0];
            act = (c > e.pop) && (c <= e.wb);
        end
        if (act) begin
            lane = c - e.pop - 1;
            if (lane < 8) begin
                exp_re = !e.instr;
                exp_we = e.instr;
            end
        end
        exp_wb   = act && (c == e.wb);
        exp_busy = 0;
        foreach (sched[i]) if (sched[i].push < c) exp_busy = 1;
        exp_ovf  = (ovf_from >= 0) && (c >= ovf_from);

        check_val("mem_re", mem_re, exp_re);
        check_val("mem_we", mem_we, exp_we);
        if (exp_re || exp_we) check_val("mem_addr", mem_addr, e.addr[lane*8 +: 8]);
        if (exp_we) check_val("mem_wdata", mem_wdata, e.data[lane*16 +: 16]);
        check_val("rf_we", rf_we, exp_wb && !e.instr);
        check_val("release_valid", release_valid, exp_wb);
        if (exp_wb) begin
            check_val("release_warp", release_warp, e.warp);
            check_val("release_reg", release_reg, e.rg);
            check_val("release_is_store", release_is_store, e.instr);
            if (!e.instr) begin
                exp_vec = '0;
                for (int k = 0; k < 8; k++) exp_vec[k*16 +: 16] = ref_mem[e.addr[k*8 +: 8]];
                check_val("rf_warp", rf_warp, e.warp);
                check_val("rf_reg", rf_reg, e.rg);
                check_val("rf_wdata", rf_wdata, exp_vec);
            end else begin
                for (int k = 0; k < 8; k++) ref_mem[e.addr[k*8 +: 8]] = e.data[k*16 +: 16];
            end
            $display("cycle %0d: WB %s warp %0d reg %0d", c, e.instr ? "store" : "load",
                     e.warp, e.rg);
        end
        check_val("busy", busy, exp_busy);
        check_val("overflow", overflow, exp_ovf);
    endtask

    // One clock cycle: update the model with this cycle's inputs, check
    // outputs mid-cycle, then move just past the next rising edge.
    task automatic step();
        if (reset) model_reset(cyc);
        else if (done_bit_q) model_push(cyc);
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic issue(input bit instr, input bit [1:0] w, input bit [3:0] r,
                         input bit [63:0] a, input bit [127:0] d);
        instr_bit_q  = instr;
        warp_num_q   = w;
        dest_reg_q   = r;
        addr_q       = a;
        store_data_q = d;
        done_bit_q   = 1'b1;
        step();
        done_bit_q   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        if (busy) check_val("idle_timeout", busy, 1'b0);
        step();
    endtask

    task automatic clear_obs();
        first_acc = -1;
        last_acc  = -1;
        last_wb   = -1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) step();
        reset = 1'b0;
    endtask

    function automatic bit [63:0] addr_vec(input int base, input int stride);
        bit [63:0] v;
        for (int k = 0; k < 8; k++) v[k*8 +: 8] = 8'(base + stride * k);
        return v;
    endfunction

    function automatic bit [127:0] data_vec(input int base);
        bit [127:0] v;
        for (int k = 0; k < 8; k++) v[k*16 +: 16] = 16'(base + k);
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n0;
        int          w0;
        bit [63:0]   ra;
        bit [127:0]  rd;
        reset = 1'b1; mem_init = 1'b1; done_bit_q = 1'b0; instr_bit_q = 1'b0;
        warp_num_q = '0; dest_reg_q = '0; addr_q = '0; store_data_q = '0;
        n_checks = 0; n_fail = 0; cyc = 0; wb_count = 0; last_rf = '0; last_store = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(240 + i);
        model_reset(0);
        clear_obs();
        @(posedge clk);
        #1;
        repeat (3) step();
        reset = 1'b0;
        mem_init = 1'b0;
        // Reset state.
        check_val("rst_rf_wdata", rf_wdata, '0);
        check_val("rst_rf_warp", rf_warp, '0);
        check_val("rst_release_reg", release_reg, '0);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_overflow", overflow, 1'b0);

        // Load across lanes 0x10+k, memory preloaded with 0x100+k there.
        clear_obs();
        n0 = cyc;
        issue(1'b0, 2'd1, 4'd3, addr_vec(16'h10, 1), '0);
        wait_idle();
        check_val("ld_first_re", first_acc, n0 + 2);
        check_val("ld_last_re", last_acc, n0 + 9);
        check_val("ld_wb_cycle", last_wb, n0 + 11);
        check_val("ld_rf_wdata", last_rf, data_vec(16'h100));

        // Store warp 2 reg 5, data 0xA0+k.
        clear_obs();
        n0 = cyc;
        issue(1'b1, 2'd2, 4'd5, addr_vec(16'h40, 1), data_vec(16'hA0));
        wait_idle();
        check_val("st_first_we", first_acc, n0 + 2);
        check_val("st_last_we", last_acc, n0 + 9);
        check_val("st_wb_cycle", last_wb, n0 + 10);
        check_val("st_is_store", last_store, 1'b1);
        check_val("st_mem47", mem[8'h47], 16'h00A7);

        // All lanes hit 0x33: the highest lane must win.
        issue(1'b1, 2'd0, 4'd1, addr_vec(16'h33, 0), data_vec(16'hB0));
        wait_idle();
        check_val("dup_mem33", mem[8'h33], 16'h00B7);

        // Store then load to the same addresses on consecutive cycles:
        // ten full cycles lie between the two WB pulses.
        w0 = wb_hist.size();
        issue(1'b1, 2'd1, 4'd2, addr_vec(16'h50, 1), data_vec(16'h5A00));
        issue(1'b0, 2'd3, 4'd9, addr_vec(16'h50, 1), '0);
        wait_idle();
        check_val("b2b_wb_count", wb_hist.size() - w0, 2);
        if (wb_hist.size() - w0 == 2)
            check_val("b2b_wb_gap", wb_hist[w0 + 1] - wb_hist[w0], 11);
        check_val("b2b_rf_wdata", last_rf, data_vec(16'h5A00));

        // Five strobes while busy with a four-deep buffer: one is dropped.
        w0 = wb_count;
        issue(1'b0, 2'd0, 4'd0, addr_vec(16'h20, 1), '0);
        step();
        for (int i = 1; i <= 5; i++)
            issue(1'b0, 2'(i), 4'(i), addr_vec(16'h10 + i, 2), '0);
        wait_idle();
        check_val("ovf_wb_count", wb_count - w0, 5);
        check_val("ovf_set", overflow, 1'b1);
        repeat (5) step();
        check_val("ovf_sticky", overflow, 1'b1);
        do_reset(1);
        check_val("ovf_cleared", overflow, 1'b0);

        // Reset at lane 4 of a load, with a strobe arriving during reset.
        n0 = cyc;
        issue(1'b0, 2'd1, 4'd7, addr_vec(16'h10, 1), '0);
        repeat (5) step();
        check_val("rst_mid_lane4", mem_addr, 8'h14);
        instr_bit_q = 1'b1; addr_q = addr_vec(16'h60, 1); store_data_q = data_vec(16'hCC);
        done_bit_q = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        done_bit_q = 1'b0;
        check_val("rst_mid_busy", busy, 1'b0);
        w0 = wb_count;
        repeat (20) step();
        check_val("rst_mid_no_wb", wb_count, w0);
        check_val("rst_mid_no_store", mem[8'h60], 16'(240 + 8'h60));
        issue(1'b0, 2'd2, 4'd4, addr_vec(16'h18, 1), '0);
        wait_idle();
        check_val("rst_mid_next", wb_count, w0 + 1);

        // Random traffic over a small address window.
        for (int t = 0; t < 80; t++) begin
            repeat ($urandom_range(0, 12)) step();
            for (int k = 0; k < 8; k++) begin
                ra[k*8 +: 8]   = 8'(8'h20 + $urandom_range(0, 15));
                rd[k*16 +: 16] = 16'($urandom);
            end
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)), ra, rd);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
